// File: rtl/cpu5_mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Load/store has priority; a starvation counter forces a fetch grant after STARVE_MAX ls wins.
module cpu5_mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic        ls_ack,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, RESP} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          drop_q, drop_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          if_ack_q, if_ack_d;
  logic          ls_ack_q, ls_ack_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;

  // A fetch being flushed this cycle is not a competing request.
  logic if_want, starved, grant_if, grant_ls;
  assign if_want  = if_req && !if_flush;
  assign starved  = (starve_q == SW'(STARVE_MAX));
  assign grant_if = if_want && (!ls_req || starved);
  assign grant_ls = ls_req && !grant_if;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
          starve_d    = '0;
        end else if (grant_ls) begin
          state_d     = BUSY_LS;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_be_d    = ls_be;
          if (!if_want)     starve_d = '0;
          else if (!starved) starve_d = starve_q + 1'b1;
        end
      end
      BUSY_IF: begin
        drop_d = drop_q | if_flush;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          drop_d    = 1'b0;
          // A flushed fetch still finishes on the bus but is silently discarded.
          if (drop_q || if_flush) begin
            state_d = IDLE;
          end else begin
            state_d    = RESP;
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      BUSY_LS: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
          ls_ack_d  = 1'b1;
          if (!mem_we_q) ls_rdata_d = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ack    = if_ack_q;
  assign ls_ack    = ls_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_cpu5_mem_arb.sv
// Scoreboard bench for cpu5_mem_arb: transaction-level reference model feeds expected
// memory requests and acks into queues; a negedge monitor pops and compares.
module tb_cpu5_mem_arb;
  localparam int STARVE_MAX = 4;

  logic        clk = 0;
  logic        resetn;
  logic        if_req, if_flush, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ack;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_be;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 0;
  logic [31:0] mem_rdata = 0;

  cpu5_mem_arb #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_ls; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int stamp; } mem_exp_t;
  typedef struct { bit is_if; int stamp; } ack_exp_t;

  mem_exp_t memq[$];
  ack_exp_t ackq[$];

  int n_vec = 0, n_bad = 0;
  bit chk_en = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bad(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: which requester owns the bus, and when it is free again.
  int          cyc_m = 0;
  int          m_ph = 0;          // 0 free, 1 fetch on bus, 2 ls on bus, 3 ack cycle
  int          m_starve = 0;
  bit          m_drop = 0, m_we = 0;
  logic [31:0] if_rd_m = 0, ls_rd_m = 0;

  initial forever begin
    bit want_if;
    @(posedge clk);
    cyc_m++;
    if (!resetn) begin
      m_ph = 0; m_starve = 0; m_drop = 0; if_rd_m = 0; ls_rd_m = 0;
      memq.delete(); ackq.delete();
    end else if (m_ph == 3) begin
      m_ph = 0;
    end else if (m_ph != 0) begin
      if (m_ph == 1 && if_flush) m_drop = 1;
      if (mem_ack) begin
        if (m_ph == 1 && m_drop) begin
          m_ph = 0; m_drop = 0;
        end else begin
          if (m_ph == 1) if_rd_m = mem_rdata;
          else if (!m_we) ls_rd_m = mem_rdata;
          ackq.push_back('{is_if: (m_ph == 1), stamp: cyc_m});
          m_ph = 3;
        end
      end
    end else begin
      want_if = if_req && !if_flush;
      if (want_if && (!ls_req || m_starve == STARVE_MAX)) begin
        memq.push_back('{is_ls: 0, we: 0, addr: if_addr, wdata: 0, be: 0, stamp: cyc_m});
        m_starve = 0; m_ph = 1;
      end else if (ls_req) begin
        memq.push_back('{is_ls: 1, we: ls_we, addr: ls_addr, wdata: ls_wdata, be: ls_be, stamp: cyc_m});
        m_we = ls_we;
        m_starve = want_if ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
        m_ph = 2;
      end
    end
  end

  // Memory responder: fixed or random latency, optional stray acks when idle.
  int          lat_fix = 0;
  bit          rd_fix_en = 0, stray_en = 0;
  logic [31:0] rd_fix = 0;
  initial begin
    bit pend = 0;
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 0;
      end else if (pend || mem_req) begin
        if (!pend) begin pend = 1; cnt = (lat_fix > 0) ? lat_fix : $urandom_range(1, 4); end
        cnt--;
        if (cnt == 0) begin
          mem_ack = 1; pend = 0;
          mem_rdata = rd_fix_en ? rd_fix : $urandom;
        end
      end else if (stray_en && $urandom_range(0, 15) == 0) begin
        mem_ack = 1; mem_rdata = $urandom;
      end
    end
  end

  // Monitor
  initial begin
    mem_exp_t cur;
    ack_exp_t a;
    bit mreq_prev = 0;
    cur = '{is_ls: 0, we: 0, addr: 0, wdata: 0, be: 0, stamp: 0};
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("mem_req", 32'(mem_req), 32'(m_ph == 1 || m_ph == 2));
        check("ack_excl", 32'(if_ack && ls_ack), 0);
        check("if_rdata", if_rdata, if_rd_m);
        check("ls_rdata", ls_rdata, ls_rd_m);
        if (mem_req && !mreq_prev) begin
          if (memq.size() == 0) bad("mem_req_unexpected");
          else begin
            cur = memq.pop_front();
            check("grant_cycle", cyc_m, cur.stamp);
          end
        end
        if (mem_req) begin
          check("mem_addr", mem_addr, cur.addr);
          check("mem_we", 32'(mem_we), 32'(cur.we));
          if (cur.is_ls) begin
            check("mem_be", 32'(mem_be), 32'(cur.be));
            if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
          end
        end
        if (if_ack || ls_ack) begin
          if (ackq.size() == 0) bad("ack_unexpected");
          else begin
            a = ackq.pop_front();
            check("ack_kind_if", 32'(if_ack), 32'(a.is_if));
            check("ack_cycle", cyc_m, a.stamp);
          end
        end else if (ackq.size() != 0 && ackq[0].stamp < cyc_m) begin
          bad("ack_missing");
          void'(ackq.pop_front());
        end
        mreq_prev = mem_req;
      end
    end
  end

  task automatic check_outputs_zero(string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_be"}, 32'(mem_be), 0);
    check({tag, "_acks"}, 32'({if_ack, ls_ack}), 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_ls_rdata"}, ls_rdata, 0);
  endtask

  task automatic new_load(input logic [31:0] addr);
    ls_req = 1; ls_we = 0; ls_addr = addr; ls_wdata = $urandom; ls_be = 4'hF;
  endtask

  // Hold current requests until each is acked; report which ack came first (0 ls, 1 if).
  task automatic drive_pending(string name, output int first);
    int n = 0;
    first = -1;
    while ((if_req || ls_req) && n < 80) begin
      @(negedge clk); n++;
      if (ls_ack) begin if (first < 0) first = 0; ls_req = 0; end
      if (if_ack) begin if (first < 0) first = 1; if_req = 0; end
    end
    if (if_req || ls_req) begin bad({name, "_timeout"}); if_req = 0; ls_req = 0; end
  endtask

  task automatic wait_mem_req(string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 20);
    if (!mem_req) bad({name, "_no_mem_req"});
  endtask

  initial begin
    int first, n, ls_n, acks;
    bit seen_if;
    logic [31:0] saved;
    resetn = 0; if_req = 0; if_addr = 0; if_flush = 0;
    ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_be = 0;
    @(negedge clk); @(negedge clk);
    chk_en = 1;
    check_outputs_zero("reset");
    resetn = 1;

    // Lone fetch
    lat_fix = 2; rd_fix = 32'h00500093; rd_fix_en = 1;
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    drive_pending("lone", first);
    check("lone_if_first", first, 1);
    check("lone_if_rdata", if_rdata, 32'h00500093);

    // Simultaneous: store wins
    rd_fix_en = 0; lat_fix = 1;
    @(negedge clk);
    if_req = 1; if_addr = 32'h200;
    ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_be = 4'hF;
    drive_pending("simul", first);
    check("simul_store_first", first, 0);

    // Starvation: back-to-back loads against a waiting fetch
    @(negedge clk);
    if_req = 1; if_addr = 32'h500; new_load(32'h3000);
    ls_n = 0; n = 0;
    while (!if_ack && n < 200) begin
      @(negedge clk); n++;
      if (ls_ack) begin ls_n++; new_load(32'h3000 + 32'(ls_n) * 4); end
    end
    if (!if_ack) bad("starve_timeout");
    check("starve_ls_grants", ls_n, STARVE_MAX);
    if_addr = 32'h600;  // fresh fetch; pending load must win again as the count restarted
    drive_pending("starve_after", first);
    check("starve_cleared", first, 0);

    // Flush during BUSY_IF
    lat_fix = 3;
    @(negedge clk);
    if_req = 1; if_addr = 32'h700; saved = if_rdata;
    wait_mem_req("flush");
    if_flush = 1; if_req = 0; new_load(32'h800);
    @(negedge clk);
    if_flush = 0;
    n = 0; seen_if = 0;
    while (!ls_ack && n < 40) begin @(negedge clk); n++; if (if_ack) seen_if = 1; end
    if (!ls_ack) bad("flush_ls_timeout");
    ls_req = 0;
    check("flush_no_if_ack", 32'(seen_if), 0);
    check("flush_if_rdata", if_rdata, saved);

    // Reset during BUSY_LS, stray mem_ack afterwards
    @(negedge clk);
    ls_req = 1; ls_we = 1; ls_addr = 32'h900; ls_wdata = 32'h12345678; ls_be = 4'h3;
    wait_mem_req("rstmid");
    resetn = 0; ls_req = 0;
    @(negedge clk);
    check_outputs_zero("rstmid");
    resetn = 1;
    acks = 0;
    repeat (8) begin @(negedge clk); if (if_ack || ls_ack) acks++; end
    check("rstmid_stray_ack", acks, 0);

    // Random traffic
    lat_fix = 0; stray_en = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (ls_ack) ls_req = 0;
      if (if_ack) if_req = 0;
      if_flush = 0;
      if (!ls_req && $urandom_range(0, 99) < 40) begin
        ls_req = 1; ls_we = $urandom_range(0, 1); ls_addr = $urandom & 32'hFFFF_FFFC;
        ls_wdata = $urandom; ls_be = 4'($urandom);
      end
      if (if_req && !if_ack && $urandom_range(0, 15) == 0) begin
        if_flush = 1; if_req = 1'($urandom_range(0, 1)); if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (!if_req && $urandom_range(0, 99) < 50) begin
        if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
    end
    n = 0;
    while ((ls_req || if_req) && n < 300) begin
      @(negedge clk); n++;
      if_flush = 0;
      if (ls_ack) ls_req = 0;
      if (if_ack) if_req = 0;
    end
    if (ls_req || if_req) bad("drain_timeout");
    stray_en = 0;
    repeat (10) @(negedge clk);
    check("drain_memq", memq.size(), 0);
    check("drain_ackq", ackq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
